// File: rtl/demorgan_sweeper_if.sv
// rtl/demorgan_sweeper_if.sv - stimulus/observe/status bundle between sweeper and its controller
interface demorgan_sweeper_if;
  logic       start;
  logic       drive_a;
  logic       drive_b;
  logic       obs_na;
  logic       obs_nb;
  logic       obs_nandnb;
  logic       obs_aandb;
  logic       obs_naandb;
  logic       obs_naornb;
  logic       obs_aorb;
  logic       obs_naorb;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [1:0] first_fail_vec;
  logic [9:0] first_fail_mask;

  modport master (
    output start,
    input  drive_a, drive_b,
    output obs_na, obs_nb, obs_nandnb, obs_aandb,
    output obs_naandb, obs_naornb, obs_aorb, obs_naorb,
    input  busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );

  modport slave (
    input  start,
    output drive_a, drive_b,
    input  obs_na, obs_nb, obs_nandnb, obs_aandb,
    input  obs_naandb, obs_naornb, obs_aorb, obs_naorb,
    output busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/demorgan_sweeper.sv
// rtl/demorgan_sweeper.sv - sweeps A/B over all four vectors and checks the De Morgan gate block
module demorgan_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  demorgan_sweeper_if.slave  bus
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    vec, vec_nx;
  logic [PW-1:0] pass_cnt, pass_cnt_nx;
  logic [SW-1:0] settle_cnt, settle_cnt_nx;
  logic          drive_a_q, drive_a_nx;
  logic          drive_b_q, drive_b_nx;
  logic [3:0]    err_q, err_nx;
  logic [1:0]    ffv_q, ffv_nx;
  logic [9:0]    ffm_q, ffm_nx;
  logic [7:0]    obs, expd;
  logic [9:0]    mask;

  // Bit order matches the mismatch mask layout: [0]nA ... [7]nAorB
  assign obs  = {bus.obs_naorb, bus.obs_aorb, bus.obs_naornb, bus.obs_naandb,
                 bus.obs_aandb, bus.obs_nandnb, bus.obs_nb, bus.obs_na};
  assign expd = {~(vec[1] | vec[0]), vec[1] | vec[0], ~vec[1] | ~vec[0], ~(vec[1] & vec[0]),
                 vec[1] & vec[0], ~vec[1] & ~vec[0], ~vec[0], ~vec[1]};
  assign mask = {obs[4] ^ obs[5], obs[2] ^ obs[7], obs ^ expd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      drive_a_q  <= 1'b0;
      drive_b_q  <= 1'b0;
      err_q      <= '0;
      ffv_q      <= '0;
      ffm_q      <= '0;
    end else begin
      state      <= state_nx;
      vec        <= vec_nx;
      pass_cnt   <= pass_cnt_nx;
      settle_cnt <= settle_cnt_nx;
      drive_a_q  <= drive_a_nx;
      drive_b_q  <= drive_b_nx;
      err_q      <= err_nx;
      ffv_q      <= ffv_nx;
      ffm_q      <= ffm_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    vec_nx        = vec;
    pass_cnt_nx   = pass_cnt;
    settle_cnt_nx = settle_cnt;
    drive_a_nx    = drive_a_q;
    drive_b_nx    = drive_b_q;
    err_nx        = err_q;
    ffv_nx        = ffv_q;
    ffm_nx        = ffm_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx      = DRIVE;
          vec_nx        = '0;
          pass_cnt_nx   = '0;
          settle_cnt_nx = '0;
          err_nx        = '0;
          ffv_nx        = '0;
          ffm_nx        = '0;
        end
      end
      DRIVE: begin
        drive_a_nx    = vec[1];
        drive_b_nx    = vec[0];
        settle_cnt_nx = '0;
        state_nx      = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      end
      SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nx = CHECK;
        else settle_cnt_nx = settle_cnt + 1'b1;
      end
      CHECK: begin
        if (mask != '0) begin
          if (err_q != 4'd15) err_nx = err_q + 4'd1;
          // err_q is still zero only until the first failure of this sweep
          if (err_q == 4'd0) begin
            ffv_nx = vec;
            ffm_nx = mask;
          end
        end
        if (vec != 2'd3) begin
          vec_nx   = vec + 2'd1;
          state_nx = DRIVE;
        end else if (pass_cnt != PW'(PASSES - 1)) begin
          vec_nx      = '0;
          pass_cnt_nx = pass_cnt + 1'b1;
          state_nx    = DRIVE;
        end else begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.drive_a         = drive_a_q;
  assign bus.drive_b         = drive_b_q;
  assign bus.busy            = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
  assign bus.done            = (state == DONE);
  assign bus.pass            = (state == DONE) && (err_q == 4'd0);
  assign bus.err_count       = err_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_mask = ffm_q;
endmodule

// File: tb/tb_demorgan_sweeper.sv
// tb/tb_demorgan_sweeper.sv - self-checking bench for demorgan_sweeper
module tb_demorgan_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0] flip [4];
  logic [2:0] start_r = 3'b000;

  demorgan_sweeper_if bus0 ();
  demorgan_sweeper_if bus1 ();
  demorgan_sweeper_if bus2 ();

  demorgan_sweeper #(.SETTLE_CYCLES(2), .PASSES(1)) u_def (.clk(clk), .rst_n(rst_n), .bus(bus0));
  demorgan_sweeper #(.SETTLE_CYCLES(0), .PASSES(1)) u_s0  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  demorgan_sweeper #(.SETTLE_CYCLES(2), .PASSES(5)) u_p5  (.clk(clk), .rst_n(rst_n), .bus(bus2));

  function automatic logic [7:0] good(input int a, input int b);
    int e [8];
    logic [7:0] r;
    e[0] = 1 - a;
    e[1] = 1 - b;
    e[2] = (a + b == 0) ? 1 : 0;
    e[3] = a * b;
    e[4] = (a * b == 0) ? 1 : 0;
    e[5] = (a == 0 || b == 0) ? 1 : 0;
    e[6] = (a + b > 0) ? 1 : 0;
    e[7] = (a + b == 0) ? 1 : 0;
    for (int i = 0; i < 8; i++) r[i] = (e[i] != 0);
    return r;
  endfunction

  logic [7:0] o0, o1, o2;
  assign o0 = good(int'(bus0.drive_a), int'(bus0.drive_b)) ^ flip[{bus0.drive_a, bus0.drive_b}];
  assign o1 = good(int'(bus1.drive_a), int'(bus1.drive_b)) ^ flip[{bus1.drive_a, bus1.drive_b}];
  assign o2 = good(int'(bus2.drive_a), int'(bus2.drive_b)) ^ flip[{bus2.drive_a, bus2.drive_b}];
  assign {bus0.obs_naorb, bus0.obs_aorb, bus0.obs_naornb, bus0.obs_naandb,
          bus0.obs_aandb, bus0.obs_nandnb, bus0.obs_nb, bus0.obs_na} = o0;
  assign {bus1.obs_naorb, bus1.obs_aorb, bus1.obs_naornb, bus1.obs_naandb,
          bus1.obs_aandb, bus1.obs_nandnb, bus1.obs_nb, bus1.obs_na} = o1;
  assign {bus2.obs_naorb, bus2.obs_aorb, bus2.obs_naornb, bus2.obs_naandb,
          bus2.obs_aandb, bus2.obs_nandnb, bus2.obs_nb, bus2.obs_na} = o2;
  assign bus0.start = start_r[0];
  assign bus1.start = start_r[1];
  assign bus2.start = start_r[2];

  // st = {busy, done, pass, drive_a, drive_b, err[3:0], ffv[1:0], ffm[9:0]}
  logic [20:0] st [3];
  assign st[0] = {bus0.busy, bus0.done, bus0.pass, bus0.drive_a, bus0.drive_b,
                  bus0.err_count, bus0.first_fail_vec, bus0.first_fail_mask};
  assign st[1] = {bus1.busy, bus1.done, bus1.pass, bus1.drive_a, bus1.drive_b,
                  bus1.err_count, bus1.first_fail_vec, bus1.first_fail_mask};
  assign st[2] = {bus2.busy, bus2.done, bus2.pass, bus2.drive_a, bus2.drive_b,
                  bus2.err_count, bus2.first_fail_vec, bus2.first_fail_mask};

  task automatic model(input int passes, output int err, output int fv, output int fm);
    err = 0; fv = 0; fm = 0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        logic [7:0] e;
        logic [7:0] o;
        int m;
        e = good(v / 2, v % 2);
        o = e ^ flip[v];
        m = 0;
        for (int i = 0; i < 8; i++) if (o[i] != e[i]) m += (1 << i);
        if (o[2] != o[7]) m += 256;
        if (o[4] != o[5]) m += 512;
        if (m != 0) begin
          if (err == 0) begin fv = v; fm = m; end
          if (err < 15) err++;
        end
      end
    end
  endtask

  task automatic set_flip(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2, input logic [7:0] f3);
    flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
  endtask

  // start raised right after edge E is sampled at E+1; done expected from E+1+passes*4*(2+settle)
  task automatic run(input int k, input int settle, input int passes, input int poke, input string name);
    int err_e, fv_e, fm_e, per, d, n, e0, drive_bad, ctrl_bad, done_at, idx;
    model(passes, err_e, fv_e, fm_e);
    per = 2 + settle;
    d = 1 + passes * 4 * per;
    drive_bad = 0; ctrl_bad = 0; done_at = -1;
    @(posedge clk); #1;
    start_r[k] = 1'b1;
    e0 = cyc;
    @(posedge clk); #1;
    start_r[k] = 1'b0;
    while (cyc - e0 <= d + 3) begin
      n = cyc - e0;
      if (n == 1) begin
        total++;
        if (st[k][15:0] !== 16'd0) begin
          bad++;
          $display("FAIL %s clear_on_start: got %h want 0", name, st[k][15:0]);
        end
      end
      if (n >= 2) begin
        idx = (n - 2 >= passes * 4 * per) ? 3 : ((n - 2) / per) % 4;
        if ({st[k][17], st[k][16]} !== 2'(idx)) drive_bad++;
      end
      if (st[k][20] !== (n >= 1 && n < d)) ctrl_bad++;
      if (st[k][19] !== (n >= d)) ctrl_bad++;
      if (st[k][18] !== (n >= d && err_e == 0)) ctrl_bad++;
      if (st[k][19] === 1'b1 && done_at < 0) done_at = n;
      start_r[k] = (n == poke);
      @(posedge clk); #1;
    end
    start_r[k] = 1'b0;
    total++;
    if (done_at != d) begin bad++; $display("FAIL %s done_edge: got %0d want %0d", name, done_at, d); end
    total++;
    if (drive_bad != 0) begin bad++; $display("FAIL %s drive_seq: got %0d wrong cycles want 0", name, drive_bad); end
    total++;
    if (ctrl_bad != 0) begin bad++; $display("FAIL %s busy_done_pass: got %0d wrong cycles want 0", name, ctrl_bad); end
    total++;
    if (st[k][15:12] !== 4'(err_e)) begin bad++; $display("FAIL %s err_count: got %0d want %0d", name, st[k][15:12], err_e); end
    total++;
    if (st[k][11:10] !== 2'(fv_e)) begin bad++; $display("FAIL %s first_fail_vec: got %0d want %0d", name, st[k][11:10], fv_e); end
    total++;
    if (st[k][9:0] !== 10'(fm_e)) begin bad++; $display("FAIL %s first_fail_mask: got %h want %h", name, st[k][9:0], 10'(fm_e)); end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (st[k] !== 21'd0) begin bad++; $display("FAIL reset_state[%0d]: got %h want 0", k, st[k]); end
    end
  endtask

  task automatic test_correct();
    set_flip(8'h00, 8'h00, 8'h00, 8'h00);
    run(0, 2, 1, -1, "correct_default");
  endtask

  task automatic test_naorb_stuck();
    set_flip(8'h80, 8'h00, 8'h00, 8'h00);
    run(0, 2, 1, -1, "naorb_stuck0");
  endtask

  task automatic test_aorb_inverted();
    set_flip(8'h40, 8'h40, 8'h40, 8'h40);
    run(0, 2, 1, -1, "aorb_inverted");
    run(2, 2, 5, -1, "aorb_inv_saturate");
  endtask

  task automatic test_settle0();
    set_flip(8'h00, 8'h00, 8'h00, 8'h00);
    run(1, 0, 1, -1, "settle0_correct");
  endtask

  task automatic test_start_while_busy();
    set_flip(8'h00, 8'h00, 8'h00, 8'h00);
    run(0, 2, 1, 5, "start_while_busy");
  endtask

  task automatic test_back_to_back();
    set_flip(8'h40, 8'h40, 8'h40, 8'h40);
    run(0, 2, 1, -1, "b2b_first");
    set_flip(8'h00, 8'h00, 8'h01, 8'h00);
    run(0, 2, 1, -1, "b2b_restart_from_done");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int k;
      for (int v = 0; v < 4; v++) flip[v] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      k = int'($urandom_range(0, 2));
      if (k == 0) run(0, 2, 1, -1, "random_def");
      else if (k == 1) run(1, 0, 1, -1, "random_s0");
      else run(2, 2, 5, -1, "random_p5");
    end
  endtask

  task automatic test_reset_mid_settle();
    int e0;
    set_flip(8'h40, 8'h40, 8'h40, 8'h40);
    @(posedge clk); #1;
    start_r[0] = 1'b1;
    e0 = cyc;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    while (cyc - e0 < 10) begin @(posedge clk); #1; end
    total++;
    if (st[0][15:12] !== 4'd2 || st[0][20] !== 1'b1) begin
      bad++; $display("FAIL pre_reset_progress: got busy=%b err=%0d want busy=1 err=2", st[0][20], st[0][15:12]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (st[k] !== 21'd0) begin bad++; $display("FAIL async_reset[%0d]: got %h want 0", k, st[k]); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (st[0] !== 21'd0) begin bad++; $display("FAIL idle_after_reset: got %h want 0", st[0]); end
  endtask

  initial begin
    set_flip(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_correct();
    test_naorb_stuck();
    test_aorb_inverted();
    test_settle0();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demorgan_sweeper.md
Name: demorgan_sweeper

Overview:
- Sequential stimulus driver and checker for the two-input De Morgan gate block.
- Drives A/B through all four input combinations, waits a settle interval, then samples the eight gate outputs.
- Checks each output against expected values and checks both De Morgan identities.
- Reports a saturating error count, the first failing vector with its mismatch mask, and a pass flag. Sits beside the gate block in the lab bench/FPGA top.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling outputs (0 allowed).
- PASSES, 1, number of full 4-vector sweeps per start (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- drive_a  out  1  registered A stimulus to the gate block.
- drive_b  out  1  registered B stimulus to the gate block.
- obs_na, obs_nb, obs_nandnb, obs_aandb, obs_naandb, obs_naornb, obs_aorb, obs_naorb  in  1 each  gate-block outputs.
- busy  out  1  high in DRIVE/SETTLE/CHECK.
- done  out  1  high while in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  4  number of failing vector checks, saturates at 15.
- first_fail_vec  out  2  {A,B} of the first failing check.
- first_fail_mask  out  10  mismatch mask of the first failing check; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, vec=0, pass counter=0, settle counter=0, drive_a=drive_b=0, busy=done=pass=0, err_count=0, first_fail_vec=0, first_fail_mask=0. Takes effect immediately, including mid-sweep; no partial results survive.
- Vector order: vec 0..3, with drive_a=vec[1] and drive_b=vec[0]. Sequence: 00, 01, 10, 11.
- FSM states:
  - IDLE: start=1 -> DRIVE. On this transition clear err_count, first_fail_*, vec and pass counter.
  - DRIVE (1 cycle): drive_a/drive_b register vec. Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
  - SETTLE: counts SETTLE_CYCLES cycles, then -> CHECK.
  - CHECK (1 cycle): sample obs_* and compute mask.
    - If vec<3: vec++ -> DRIVE.
    - Else if pass counter < PASSES-1: vec=0, pass counter++ -> DRIVE.
    - Else -> DONE.
  - DONE: done=1, outputs held. start=1 -> same as IDLE start (clear and restart).
- start is ignored while busy.
- drive_a/drive_b hold their last value in SETTLE, CHECK and DONE; they return to 0 only on reset.
- Expected values for inputs a,b:
  - nA=~a, nB=~b
  - nAandnB=~a&~b, AandB=a&b
  - nAandB=~(a&b), nAornB=~a|~b
  - AorB=a|b, nAorB=~(a|b)
- Mask bits [7:0]: obs != expected, in order [0]nA [1]nB [2]nAandnB [3]AandB [4]nAandB [5]nAornB [6]AorB [7]nAorB.
- Mask bit [8]: obs_nandnb != obs_naorb. Mask bit [9]: obs_naandb != obs_naornb.
- A check fails if mask != 0.
  - On failure, err_count increments, saturating at 15.
  - On the first failure of the sweep only, capture first_fail_vec=vec and first_fail_mask=mask.
- Latency: each vector takes 2+SETTLE_CYCLES cycles. done rises at edge 1 + PASSES*4*(2+SETTLE_CYCLES) after the edge that samples start. With defaults, that is edge 17.
- pass is combinational from done and err_count; it is never 1 outside DONE.

Test Plan:
- Correct gate model, defaults, start pulse at edge 0 -> drive sequence 00,01,10,11, each held 4 cycles; done=1 from edge 17; pass=1, err_count=0, first_fail_mask=0.
- obs_naorb stuck-at-0, others correct -> only vec 00 fails; err_count=1, first_fail_vec=00, first_fail_mask=0x180, pass=0.
- obs_aorb inverted -> all 4 vectors fail; err_count=4, first_fail_vec=00, first_fail_mask=0x040. Rerun with PASSES=5 -> err_count saturates at 15.
- SETTLE_CYCLES=0, correct model -> each vector lasts 2 cycles; done at edge 9; pass=1.
- start pulsed again at edge 6 (busy) -> ignored, done still at edge 17. start in DONE -> err_count/first_fail cleared, new sweep, done 17 cycles later.
- rst_n low mid-SETTLE of vec 2 -> all outputs 0 immediately, state IDLE; after release, no activity until start.
